// File: rtl/fixedpoint_div_s.sv
// Sequential signed fixed-point divider: Q6.1 dividend / Q3.4 divisor -> Q3.4 quotient.
// Restoring division, one quotient bit per clock, round half away from zero, saturating.
module fixedpoint_div_s (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic       ovf,
    output logic       dz
);
    localparam int unsigned W  = 8;
    localparam int unsigned NW = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND, S_DONE} state_t;

    state_t        r_state, w_state_nx;
    logic [NW-1:0] r_num, w_num_nx;
    logic [W-1:0]  r_dm, w_dm_nx;
    logic [W-1:0]  r_rem, w_rem_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_neg, w_neg_nx;
    logic          r_dsign, w_dsign_nx;
    logic          r_zero, w_zero_nx;
    logic          r_dzp, w_dzp_nx;
    logic [W-1:0]  r_quot, w_quot_nx;
    logic          r_ovf, w_ovf_nx;
    logic          r_dz, w_dz_nx;
    logic          r_busy, w_busy_nx;
    logic          r_done, w_done_nx;

    logic [W-1:0]  w_dd_mag, w_dv_mag;
    logic [W:0]    w_rem_sh, w_diff;
    logic          w_qbit;
    logic [NW-1:0] w_r;

    // Magnitudes fit 8 unsigned bits: 0x80 maps to 128
    assign w_dd_mag = dividend[7] ? W'(~dividend) + W'(1) : dividend;
    assign w_dv_mag = divisor[7]  ? W'(~divisor)  + W'(1) : divisor;

    // One restoring step: remainder stays below dm, so 9 bits hold the shifted value
    assign w_rem_sh = {r_rem, r_num[NW-1]};
    assign w_qbit   = (w_rem_sh >= {1'b0, r_dm});
    assign w_diff   = w_rem_sh - {1'b0, r_dm};
    assign w_r      = NW'(({1'b0, r_num} + 17'd1) >> 1);

    always_comb begin
        w_state_nx = r_state;
        w_num_nx   = r_num;
        w_dm_nx    = r_dm;
        w_rem_nx   = r_rem;
        w_cnt_nx   = r_cnt;
        w_neg_nx   = r_neg;
        w_dsign_nx = r_dsign;
        w_zero_nx  = r_zero;
        w_dzp_nx   = r_dzp;
        w_quot_nx  = r_quot;
        w_ovf_nx   = r_ovf;
        w_dz_nx    = r_dz;

        case (r_state)
            S_CALC: begin
                w_rem_nx = w_qbit ? W'(w_diff) : W'(w_rem_sh);
                w_num_nx = {r_num[NW-2:0], w_qbit};
                w_cnt_nx = r_cnt + CW'(1);
                if (r_cnt == CW'(NW - 1)) begin
                    w_state_nx = S_ROUND;
                end
            end
            S_ROUND: begin
                w_state_nx = S_DONE;
                if (r_dzp) begin
                    w_quot_nx = r_dsign ? 8'h80 : 8'h7F;
                    w_ovf_nx  = 1'b1;
                    w_dz_nx   = 1'b1;
                end else if (r_zero) begin
                    w_quot_nx = 8'h00;
                end else if (!r_neg) begin
                    if (w_r > NW'(127)) begin
                        w_quot_nx = 8'h7F;
                        w_ovf_nx  = 1'b1;
                    end else begin
                        w_quot_nx = W'(w_r);
                    end
                end else begin
                    if (w_r > NW'(128)) begin
                        w_quot_nx = 8'h80;
                        w_ovf_nx  = 1'b1;
                    end else begin
                        w_quot_nx = W'(~w_r) + W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Accept from IDLE or DONE (back-to-back)
        if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
            w_num_nx   = {w_dd_mag, 8'h00};
            w_dm_nx    = w_dv_mag;
            w_rem_nx   = '0;
            w_cnt_nx   = '0;
            w_neg_nx   = dividend[7] ^ divisor[7];
            w_dsign_nx = dividend[7];
            w_zero_nx  = (dividend == 8'h00);
            w_dzp_nx   = (divisor == 8'h00);
            w_ovf_nx   = 1'b0;
            w_dz_nx    = 1'b0;
            w_state_nx = (divisor == 8'h00) ? S_ROUND : S_CALC;
        end

        w_busy_nx = (w_state_nx == S_CALC) || (w_state_nx == S_ROUND);
        w_done_nx = (w_state_nx == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_dm    <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_dsign <= 1'b0;
            r_zero  <= 1'b0;
            r_dzp   <= 1'b0;
            r_quot  <= '0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_num   <= w_num_nx;
            r_dm    <= w_dm_nx;
            r_rem   <= w_rem_nx;
            r_cnt   <= w_cnt_nx;
            r_neg   <= w_neg_nx;
            r_dsign <= w_dsign_nx;
            r_zero  <= w_zero_nx;
            r_dzp   <= w_dzp_nx;
            r_quot  <= w_quot_nx;
            r_ovf   <= w_ovf_nx;
            r_dz    <= w_dz_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quot;
    assign ovf      = r_ovf;
    assign dz       = r_dz;
endmodule

// File: tb/tb_fixedpoint_div_s.sv
// Directed bench for fixedpoint_div_s: hand-computed quotients, latency, handshake and reset.
module tb_fixedpoint_div_s;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic       ovf;
    logic       dz;

    int n_vec = 0;
    int n_err = 0;

    fixedpoint_div_s dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation; operands are scrambled after accept and a stray start is pulsed while busy
    task automatic run_op(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                          input logic [7:0] eq, input logic eo, input logic ez, input int elat);
        int n;
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(negedge clk);
        start = 1'b0; dividend = ~dd; divisor = 8'h00;
        n = 1;
        chk({tag, " busy"}, 16'(busy), 16'(1));
        while (!done && n < 40) begin
            if (n == 3) begin
                start = 1'b1; dividend = 8'h55; divisor = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 16'(n), 16'(elat));
        chk({tag, " quotient"}, 16'(quotient), 16'(eq));
        chk({tag, " ovf"}, 16'(ovf), 16'(eo));
        chk({tag, " dz"}, 16'(dz), 16'(ez));
        @(negedge clk);
        chk({tag, " done_pulse"}, 16'({done, busy}), 16'(0));
        chk({tag, " hold"}, 16'(quotient), 16'(eq));
    endtask

    initial begin
        int  n;
        logic seen;
        rst = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset outputs", 16'({busy, done, ovf, dz, quotient}), 16'(0));

        run_op("3.0/1.5",    8'h06, 8'h18, 8'h20, 1'b0, 1'b0, 18);
        run_op("0.5/3.0",    8'h01, 8'h30, 8'h03, 1'b0, 1'b0, 18);
        run_op("-3.0/1.5",   8'hFA, 8'h18, 8'hE0, 1'b0, 1'b0, 18);
        run_op("sat pos",    8'h7F, 8'h01, 8'h7F, 1'b1, 1'b0, 18);
        run_op("sat neg",    8'h80, 8'h01, 8'h80, 1'b1, 1'b0, 18);
        run_op("dz neg",     8'hF0, 8'h00, 8'h80, 1'b1, 1'b1, 2);
        run_op("dz zero",    8'h00, 8'h00, 8'h7F, 1'b1, 1'b1, 2);
        run_op("zero dvd",   8'h00, 8'h18, 8'h00, 1'b0, 1'b0, 18);
        run_op("-8 exact",   8'hF0, 8'h10, 8'h80, 1'b0, 1'b0, 18);
        run_op("+8 sat",     8'h10, 8'h10, 8'h7F, 1'b1, 1'b0, 18);
        run_op("-64/-8 sat", 8'h80, 8'h80, 8'h7F, 1'b1, 1'b0, 18);
        run_op("small neg",  8'hFF, 8'h7F, 8'hFF, 1'b0, 1'b0, 18);
        run_op("32/-8",      8'h40, 8'h80, 8'hC0, 1'b0, 1'b0, 18);

        // Reset in the middle of CALC aborts without done
        @(negedge clk);
        start = 1'b1; dividend = 8'h06; divisor = 8'h18;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", 16'(busy), 16'(0));
        chk("rst quotient", 16'(quotient), 16'(0));
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("rst no done", 16'(seen), 16'(0));
        run_op("after rst",  8'h06, 8'h18, 8'h20, 1'b0, 1'b0, 18);

        // Back-to-back with start held high; operands garbage while busy
        @(negedge clk);
        start = 1'b1; dividend = 8'h0C; divisor = 8'h20;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                dividend = 8'h7F; divisor = 8'h00;
            end
        end
        chk("b2b first latency", 16'(n), 16'(18));
        chk("b2b first quotient", 16'(quotient), 16'(8'h30));
        dividend = 8'h40; divisor = 8'h80;
        n = 0;
        @(negedge clk);
        n++;
        chk("b2b busy again", 16'({busy, done}), 16'(2));
        dividend = 8'h7F; divisor = 8'h00;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("b2b second latency", 16'(n), 16'(18));
        chk("b2b second quotient", 16'(quotient), 16'(8'hC0));
        chk("b2b second flags", 16'({ovf, dz}), 16'(0));
        @(negedge clk);
        chk("b2b idle", 16'({busy, done}), 16'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
